ucc_call_integrity: RTL and testbench
=====================================

Name: ucc_call_integrity

Overview:
- Caller-side companion to the UCC return-address monitor.
- That monitor checks that control returns into the UCC correctly after the UCC calls out. This block checks the opposite direction:
  - outside code may enter the UCC only at its single entry point;
  - when the UCC returns to its caller, it must land on the caller's return address.
- Keeps a small shadow stack of caller return addresses so nested re-entry through outcall callbacks is supported.
- Drives a registered reset request into the system reset OR-tree.

Parameters:
- UCC_MIN, 16'hE000, lowest UCC address (inclusive)
- UCC_MAX, 16'hE0FF, highest UCC address (inclusive)
- UCC_ENTRY, 16'hE000, only legal entry address
- RESET_HANDLER, 16'h0000, reset vector; lockout is released here
- DEPTH, 4, shadow stack entries (2..16)
- DW, 3, depth counter width, equal to clog2(DEPTH+1)

Ports:
- clk  in  1  system clock, rising edge
- system_reset_n  in  1  asynchronous active-low reset
- pc  in  16  current instruction address
- pc_en  in  1  pc valid / instruction retire strobe; all checks sample only when high
- instr_is_call  in  1  instruction at the previous pc was a call
- instr_is_ret  in  1  instruction at the previous pc was a return
- caller_ret  in  16  return address of the previous instruction (prev pc + instruction length), valid with pc_en
- irq  in  1  interrupt being serviced
- system_reset  in  1  active-high reset request from other modules
- depth  out  DW  shadow stack occupancy (for formal verification)
- top_return_address  out  16  stack top, 16'h0000 when empty (for formal verification)
- reset  out  1  registered violation / lockout reset request

Behaviour:
- Derived signals:
  - in_now = UCC_MIN ≤ pc ≤ UCC_MAX
  - in_prev = registered in_now, updated only on pc_en
- Event classification (on pc_en, with irq low):
  - entry: !in_prev && in_now && !instr_is_ret
  - re-return: !in_prev && in_now && instr_is_ret. Ignored here; covered by the return monitor.
  - leave: in_prev && !in_now && instr_is_ret
  - outcall: in_prev && !in_now && !instr_is_ret. Ignored here.
- FSM states: LOCK, NOT_UCC, IN_UCC, IRQ.
- Async reset:
  - state=LOCK, depth=0, all stack entries 16'h0000, in_prev=0, reset=1.
- LOCK:
  - Stack held clear.
  - Leave LOCK for NOT_UCC when pc==RESET_HANDLER && !system_reset; else stay.
- NOT_UCC / IN_UCC:
  - entry with pc==UCC_ENTRY and depth<DEPTH: push caller_ret, depth+1, go to IN_UCC.
  - entry with pc!=UCC_ENTRY: violation.
  - entry with depth==DEPTH (overflow): violation.
  - leave with depth==0 (underflow): violation.
  - leave with pc!=top: violation.
  - leave with pc==top: pop, depth-1. Next state is NOT_UCC if the new depth is 0; otherwise stay in IN_UCC, because an outer caller frame is still open.
  - An outcall from IN_UCC moves to NOT_UCC without a stack change. A later re-return moves back to IN_UCC.
- IRQ:
  - Entered from NOT_UCC or IN_UCC when irq=1.
  - No checks; stack, depth and in_prev frozen.
  - When irq falls, return to the pre-IRQ state (saved in a 1-bit register).
- Violation:
  - Next cycle: reset=1, stack cleared, state=LOCK.
  - reset stays 1 while in LOCK, and is 0 otherwise (registered).
- system_reset=1 in any state:
  - Stack cleared, depth=0, state=LOCK on the next edge.
  - Takes priority over a simultaneous push or pop.
- Simultaneous irq and event on the same pc_en: irq wins, and the event is not evaluated.
- pc_en low: no state, stack or in_prev change.
- Width rules:
  - Depth arithmetic is unsigned DW bits and never wraps. Overflow and underflow are violations before any update.
  - top_return_address is the entry at index depth-1.

Optional Feature:
- Macro: UCC_STRICT_ENTRY_EN.
- Defined:
  - entry additionally requires instr_is_call=1.
  - Entry by a jump or fall-through is a violation even at UCC_ENTRY.
- Undefined:
  - Any non-return transfer landing on UCC_ENTRY is accepted; instr_is_call is unused except for the port.

Test Plan:
- Release from reset with pc=0000, then call from 8010 to E000 with caller_ret=8014 → depth=1, top=8014, reset=0.
- Then leave the UCC with ret to 8014 → depth=0, state NOT_UCC, reset=0.
- From NOT_UCC, call from 8010 to E004 → reset=1 one cycle later, depth=0.
  - reset stays 1 until pc=0000 with system_reset=0.
- Enter the UCC (top=8014), then ret to 8018 → reset=1.
  - Separately, ret from the UCC with depth=0 → reset=1.
- Nesting:
  - Enter the UCC (caller_ret=8014), outcall to 9000, callback call to E000 (caller_ret=9006) → depth=2, top=9006.
  - Ret to 9006 → depth=1, top=8014.
  - Five nested entries with DEPTH=4 → reset=1 on the 5th.
- Enter the UCC, raise irq, pc jumps to F000, deassert irq and pc returns to E020 → no reset, depth=1.
- Macro set: jump (instr_is_call=0) to E000 → reset=1.
- system_reset pulse mid-nest → depth=0, state LOCK.

Source files
------------

// File: rtl/ucc_call_integrity.sv
// ucc_call_integrity: entry-point and caller-return checker for the UCC with a shadow return stack.
// Define UCC_STRICT_ENTRY_EN to require that every UCC entry is made by a call instruction.
module ucc_call_integrity #(
   parameter logic [15:0] UCC_MIN       = 16'hE000,
   parameter logic [15:0] UCC_MAX       = 16'hE0FF,
   parameter logic [15:0] UCC_ENTRY     = 16'hE000,
   parameter logic [15:0] RESET_HANDLER = 16'h0000,
   parameter int          DEPTH         = 4,
   parameter int          DW            = 3
) (
   input  logic          clk,
   input  logic          system_reset_n,
   input  logic [15:0]   pc,
   input  logic          pc_en,
   input  logic          instr_is_call,
   input  logic          instr_is_ret,
   input  logic [15:0]   caller_ret,
   input  logic          irq,
   input  logic          system_reset,
   output logic [DW-1:0] depth,
   output logic [15:0]   top_return_address,
   output logic          reset
);
   localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
   localparam logic [DW-1:0] FULL = DW'(DEPTH);
   localparam logic [DW-1:0] ONE  = DW'(1);

   typedef enum logic [1:0] {LOCK, NOT_UCC, IN_UCC, IRQ} st_t;
   st_t state, state_n;

   logic [15:0]   stk [DEPTH];
   logic          in_prev, in_now, saved_in_ucc;
   logic          active, sample, entry, rereturn, leave, outcall, bad_call;
   logic          viol, push, pop, clear;
   logic [DW-1:0] dm1;

`ifdef UCC_STRICT_ENTRY_EN
   assign bad_call = !instr_is_call;
`else
   assign bad_call = instr_is_call & 1'b0;
`endif

   assign in_now   = pc >= UCC_MIN && pc <= UCC_MAX;
   assign active   = state == NOT_UCC || state == IN_UCC;
   assign sample   = pc_en && !irq;
   assign entry    = sample && !in_prev && in_now && !instr_is_ret;
   assign rereturn = sample && !in_prev && in_now && instr_is_ret;
   assign leave    = sample && in_prev && !in_now && instr_is_ret;
   assign outcall  = sample && in_prev && !in_now && !instr_is_ret;
   assign dm1      = depth - ONE;
   assign top_return_address = depth == '0 ? 16'h0000 : stk[dm1[AW-1:0]];

   always_ff @(posedge clk or negedge system_reset_n)
      if (!system_reset_n) begin
         state        <= LOCK;
         reset        <= 1'b1;
         saved_in_ucc <= 1'b0;
      end else begin
         state        <= state_n;
         reset        <= state_n == LOCK;
         saved_in_ucc <= active && pc_en && irq ? state == IN_UCC : saved_in_ucc;
      end

   always_comb begin
      state_n = state;
      case (state)
         LOCK:    state_n = pc_en && pc == RESET_HANDLER ? NOT_UCC : LOCK;
         IRQ:     state_n = pc_en && !irq ? (saved_in_ucc ? IN_UCC : NOT_UCC) : IRQ;
         default: state_n = pc_en && irq ? IRQ :
                            viol         ? LOCK :
                            push         ? IN_UCC :
                            pop          ? (depth == ONE ? NOT_UCC : IN_UCC) :
                            outcall      ? NOT_UCC :
                            rereturn     ? IN_UCC : state;
      endcase
      if (system_reset) state_n = LOCK;
   end

   always_comb begin
      viol  = active && !system_reset &&
              ((entry && (pc != UCC_ENTRY || depth == FULL || bad_call)) ||
               (leave && (depth == '0 || pc != top_return_address)));
      push  = active && !system_reset && entry && !viol;
      pop   = active && !system_reset && leave && !viol;
      clear = system_reset || viol || state == LOCK;
   end

   // in_prev follows the retired pc except while an interrupt is being serviced
   always_ff @(posedge clk or negedge system_reset_n)
      if (!system_reset_n) in_prev <= 1'b0;
      else if (pc_en && state != IRQ && !(active && irq)) in_prev <= in_now;

   always_ff @(posedge clk or negedge system_reset_n)
      if (!system_reset_n) begin
         depth <= '0;
         for (int i = 0; i < DEPTH; i++) stk[i] <= 16'h0000;
      end else if (clear) begin
         depth <= '0;
         for (int i = 0; i < DEPTH; i++) stk[i] <= 16'h0000;
      end else if (push) begin
         stk[depth[AW-1:0]] <= caller_ret;
         depth              <= depth + ONE;
      end else if (pop) begin
         stk[dm1[AW-1:0]] <= 16'h0000;
         depth            <= dm1;
      end
endmodule

// File: tb/tb_ucc_call_integrity.sv
// tb_ucc_call_integrity: directed scenario tests for ucc_call_integrity.
module tb_ucc_call_integrity;
   logic        clk = 1'b0;
   logic        system_reset_n = 1'b0;
   logic [15:0] pc = 16'h0000;
   logic        pc_en = 1'b0;
   logic        instr_is_call = 1'b0;
   logic        instr_is_ret = 1'b0;
   logic [15:0] caller_ret = 16'h0000;
   logic        irq = 1'b0;
   logic        system_reset = 1'b0;
   logic [2:0]  depth;
   logic [15:0] top_return_address;
   logic        reset;
   int          checks = 0;
   int          fails = 0;

   ucc_call_integrity dut (
      .clk(clk), .system_reset_n(system_reset_n), .pc(pc), .pc_en(pc_en),
      .instr_is_call(instr_is_call), .instr_is_ret(instr_is_ret), .caller_ret(caller_ret),
      .irq(irq), .system_reset(system_reset), .depth(depth),
      .top_return_address(top_return_address), .reset(reset)
   );

   always #5 clk = ~clk;

   task automatic step(input logic [15:0] p, input logic call = 1'b0, input logic ret = 1'b0,
                       input logic [15:0] cr = 16'h0000, input logic i = 1'b0,
                       input logic sr = 1'b0, input logic en = 1'b1);
      pc = p; instr_is_call = call; instr_is_ret = ret; caller_ret = cr;
      irq = i; system_reset = sr; pc_en = en;
      @(posedge clk); #1;
      pc_en = 1'b0; irq = i; system_reset = 1'b0;
   endtask

   task automatic test_reset;
      #12;
      checks++; if (depth !== 3'd0) begin fails++; $display("FAIL rst_depth got %0d exp 0", depth); end
      checks++; if (top_return_address !== 16'h0000) begin fails++; $display("FAIL rst_top got %h exp 0000", top_return_address); end
      checks++; if (reset !== 1'b1) begin fails++; $display("FAIL rst_reset got %b exp 1", reset); end
      system_reset_n = 1'b1;
      @(posedge clk); #1;
      step(16'h0000);
      checks++; if (reset !== 1'b0) begin fails++; $display("FAIL release got %b exp 0", reset); end
   endtask

   task automatic test_call_ret;
      step(16'h8010);
      step(16'hE000, 1, 0, 16'h8014);
      checks++; if (depth !== 3'd1) begin fails++; $display("FAIL call_depth got %0d exp 1", depth); end
      checks++; if (top_return_address !== 16'h8014) begin fails++; $display("FAIL call_top got %h exp 8014", top_return_address); end
      checks++; if (reset !== 1'b0) begin fails++; $display("FAIL call_reset got %b exp 0", reset); end
      step(16'hE010);
      step(16'h8018, 0, 1, 16'h0000, 0, 0, 0);
      checks++; if (depth !== 3'd1 || reset !== 1'b0) begin fails++; $display("FAIL pc_en_low depth %0d reset %b exp 1 0", depth, reset); end
      step(16'h8014, 0, 1);
      checks++; if (depth !== 3'd0 || reset !== 1'b0) begin fails++; $display("FAIL ret_ok depth %0d reset %b exp 0 0", depth, reset); end
   endtask

   task automatic test_bad_entry;
      step(16'h8010);
      step(16'hE004, 1, 0, 16'h8014);
      checks++; if (reset !== 1'b1 || depth !== 3'd0) begin fails++; $display("FAIL bad_entry reset %b depth %0d exp 1 0", reset, depth); end
      step(16'h8000);
      checks++; if (reset !== 1'b1) begin fails++; $display("FAIL lock_hold got %b exp 1", reset); end
      step(16'h0000, 0, 0, 16'h0000, 0, 1);
      checks++; if (reset !== 1'b1) begin fails++; $display("FAIL lock_sysrst got %b exp 1", reset); end
      step(16'h0000);
      checks++; if (reset !== 1'b0) begin fails++; $display("FAIL lock_release got %b exp 0", reset); end
   endtask

   task automatic test_bad_ret;
      step(16'hE000, 1, 0, 16'h8014);
      step(16'h8018, 0, 1);
      checks++; if (reset !== 1'b1 || depth !== 3'd0) begin fails++; $display("FAIL wrong_ret reset %b depth %0d exp 1 0", reset, depth); end
      step(16'h0000);
      step(16'hE000, 0, 1);
      checks++; if (reset !== 1'b0 || depth !== 3'd0) begin fails++; $display("FAIL reret_ignored reset %b depth %0d exp 0 0", reset, depth); end
      step(16'h8000, 0, 1);
      checks++; if (reset !== 1'b1) begin fails++; $display("FAIL underflow got %b exp 1", reset); end
      step(16'h0000);
   endtask

   task automatic test_nesting;
      step(16'hE000, 1, 0, 16'h8014);
      step(16'h9000, 1, 0);
      step(16'hE000, 1, 0, 16'h9006);
      checks++; if (depth !== 3'd2 || top_return_address !== 16'h9006) begin fails++; $display("FAIL nest_push depth %0d top %h exp 2 9006", depth, top_return_address); end
      step(16'h9006, 0, 1);
      checks++; if (depth !== 3'd1 || top_return_address !== 16'h8014 || reset !== 1'b0) begin fails++; $display("FAIL nest_pop depth %0d top %h reset %b exp 1 8014 0", depth, top_return_address, reset); end
      step(16'hE000, 0, 1);
      step(16'h8014, 0, 1);
      checks++; if (depth !== 3'd0 || reset !== 1'b0) begin fails++; $display("FAIL nest_unwind depth %0d reset %b exp 0 0", depth, reset); end
      for (int i = 0; i < 5; i++) begin
         step(16'hE000, 1, 0, 16'h8014 + 16'(i));
         if (i == 3) begin
            checks++; if (depth !== 3'd4 || top_return_address !== 16'h8017 || reset !== 1'b0) begin fails++; $display("FAIL nest_full depth %0d top %h reset %b exp 4 8017 0", depth, top_return_address, reset); end
         end
         step(16'h9000, 1, 0);
      end
      checks++; if (reset !== 1'b1 || depth !== 3'd0) begin fails++; $display("FAIL overflow reset %b depth %0d exp 1 0", reset, depth); end
      step(16'h0000);
   endtask

   task automatic test_irq;
      step(16'hE000, 1, 0, 16'h8014);
      step(16'hF000, 0, 0, 16'h0000, 1);
      checks++; if (depth !== 3'd1 || reset !== 1'b0) begin fails++; $display("FAIL irq_in depth %0d reset %b exp 1 0", depth, reset); end
      step(16'hE020);
      checks++; if (depth !== 3'd1 || reset !== 1'b0) begin fails++; $display("FAIL irq_out depth %0d reset %b exp 1 0", depth, reset); end
      step(16'h8014, 0, 1);
      checks++; if (depth !== 3'd0 || reset !== 1'b0) begin fails++; $display("FAIL irq_ret depth %0d reset %b exp 0 0", depth, reset); end
   endtask

   task automatic test_strict;
      logic       exp_reset;
      logic [2:0] exp_depth;
`ifdef UCC_STRICT_ENTRY_EN
      exp_reset = 1'b1; exp_depth = 3'd0;
`else
      exp_reset = 1'b0; exp_depth = 3'd1;
`endif
      step(16'h8010);
      step(16'hE000, 0, 0, 16'h8014);
      checks++; if (reset !== exp_reset || depth !== exp_depth) begin fails++; $display("FAIL jump_entry reset %b depth %0d exp %b %0d", reset, depth, exp_reset, exp_depth); end
      step(16'h0000, 0, 0, 16'h0000, 0, 1);
      step(16'h0000);
   endtask

   task automatic test_sysreset;
      step(16'hE000, 1, 0, 16'h8014);
      step(16'h9000, 1, 0);
      step(16'hE000, 1, 0, 16'h9006);
      step(16'hE010, 0, 0, 16'h0000, 0, 1);
      checks++; if (depth !== 3'd0 || reset !== 1'b1 || top_return_address !== 16'h0000) begin fails++; $display("FAIL sysrst depth %0d reset %b top %h exp 0 1 0000", depth, reset, top_return_address); end
      step(16'h0000);
      checks++; if (reset !== 1'b0) begin fails++; $display("FAIL sysrst_release got %b exp 0", reset); end
   endtask

   initial begin
      test_reset;
      test_call_ret;
      test_bad_entry;
      test_bad_ret;
      test_nesting;
      test_irq;
      test_strict;
      test_sysreset;
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
